// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode, funct, ALU code and mux select encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - R-type funct field to ALU operation code and validity flag
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_operation_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_operation_o = ALU_NOP;
    funct_valid_o   = 1'b1;
    case (funct_i)
      FUNCT_ADD: alu_operation_o = ALU_ADD;
      FUNCT_SUB: alu_operation_o = ALU_SUB;
      FUNCT_OR:  alu_operation_o = ALU_OR;
      FUNCT_SLL: alu_operation_o = ALU_SLL;
      default:   funct_valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS controller FSM with wait-state memory
module multicycle_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       ext_sel_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] alu_operation_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state;
  logic       is_store;
  logic       is_bne;
  logic [3:0] funct_op;
  logic       funct_valid;
  logic       opcode_legal;

  alu_op_decoder u_alu_op_decoder (
    .funct_i         (funct_i),
    .alu_operation_o (funct_op),
    .funct_valid_o   (funct_valid)
  );

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode_i)
      OP_RTYPE: opcode_legal = funct_valid;
      OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // lw/sw and beq/bne variants are latched in DECODE so later states need no opcode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
      is_bne   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          is_store <= (opcode_i == OP_SW);
          is_bne   <= (opcode_i == OP_BNE);
          case (opcode_i)
            OP_LW, OP_SW:          state <= S_MEM_ADDR;
            OP_RTYPE:              state <= funct_valid ? S_EXEC_R : S_FETCH;
            OP_ADDI, OP_ORI, OP_LUI: state <= S_EXEC_I;
            OP_BEQ, OP_BNE:        state <= S_BRANCH;
            OP_J:                  state <= S_JUMP;
            default:               state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  state <= is_store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready_i) state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready_i) state <= S_FETCH;
        S_EXEC_R:    state <= S_R_WB;
        S_EXEC_I:    state <= S_I_WB;
        default:     state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    ext_sel_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRC_B_REG;
    pc_src_o        = PC_SRC_ALU;
    alu_operation_o = ALU_NOP;
    illegal_o       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o      = 1'b1;
        alu_src_b_o     = SRC_B_FOUR;
        alu_operation_o = ALU_ADD;
        ir_write_o      = mem_ready_i;
        pc_write_o      = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o     = SRC_B_IMM_SH2;
        alu_operation_o = ALU_ADD;
        illegal_o       = !opcode_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = SRC_B_IMM;
        alu_operation_o = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o     = 1'b1;
        alu_operation_o = funct_op;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_operation_o = ALU_SUB;
        pc_src_o        = PC_SRC_ALUOUT;
        pc_write_o      = is_bne ? !zero_i : zero_i;
      end
      S_JUMP: begin
        pc_src_o   = PC_SRC_JUMP;
        pc_write_o = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRC_B_IMM;
        case (opcode_i)
          OP_ADDI: alu_operation_o = ALU_ADD;
          OP_ORI: begin
            alu_operation_o = ALU_OR;
            ext_sel_o       = 1'b1;
          end
          OP_LUI:  alu_operation_o = ALU_LUI;
          default: alu_operation_o = ALU_NOP;
        endcase
      end
      S_I_WB: reg_write_o = 1'b1;
      default: ;
    endcase
    // Reset suppresses every write regardless of what the state decode says
    if (!reset) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode_i = 6'd0;
  logic [5:0] funct_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, reg_write_o;
  logic       reg_dst_o, mem_to_reg_o, ext_sel_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [3:0] alu_operation_o, state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rgw, mr, mw, iord, rdst, m2r, ext, sa;
    logic [1:0] sb, ps;
    logic [3:0] op;
    logic ill;
  } obs_t;

  typedef struct {
    logic rdy;
    logic zr;
    obs_t e;
  } step_t;

  step_t q[$];

  multicycle_control_unit dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode_i),
    .funct_i         (funct_i),
    .zero_i          (zero_i),
    .mem_ready_i     (mem_ready_i),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .iord_o          (iord_o),
    .ir_write_o      (ir_write_o),
    .pc_write_o      (pc_write_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .ext_sel_o       (ext_sel_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .pc_src_o        (pc_src_o),
    .alu_operation_o (alu_operation_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] st, input logic pcw, irw, rgw, mr, mw, iord,
                              rdst, m2r, ext, sa, input logic [1:0] sb, ps,
                              input logic [3:0] op, input logic ill);
    return '{st, pcw, irw, rgw, mr, mw, iord, rdst, m2r, ext, sa, sb, ps, op, ill};
  endfunction

  function automatic obs_t observe();
    return '{state_o, pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, iord_o,
             reg_dst_o, mem_to_reg_o, ext_sel_o, alu_src_a_o, alu_src_b_o, pc_src_o,
             alu_operation_o, illegal_o};
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    return mk(4'd0, rdy, rdy, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0011, 0);
  endfunction

  function automatic obs_t e_decode(input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0011, ill);
  endfunction

  task automatic push(input logic rdy, input logic zr, input obs_t e);
    step_t s;
    s.rdy = rdy;
    s.zr  = zr;
    s.e   = e;
    q.push_back(s);
  endtask

  task automatic test_reset();
    step_t s;
    obs_t  o;
    mem_ready_i = 1'b1;
    opcode_i    = 6'b000010;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (state_o !== 4'd0 || pc_write_o !== 1'b0 || ir_write_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold state=%0d pcw=%b irw=%b required 0/0/0", state_o, pc_write_o, ir_write_o);
      end
      checks++;
      if (mem_read_o !== 1'b1 || alu_src_b_o !== 2'b01 || alu_operation_o !== 4'b0011 || illegal_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_fetch_vals mr=%b sb=%b op=%b ill=%b required 1/01/0011/0",
                 mem_read_o, alu_src_b_o, alu_operation_o, illegal_o);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push(1, 0, e_fetch(1));
    push(1, 0, e_decode(0));
    push(1, 0, mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      mem_ready_i = s.rdy; zero_i = s.zr;
      @(negedge clk); o = observe(); checks++;
      if (o !== s.e) begin errors++; $display("FAIL reset_release_j got %h required %h", o, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    step_t s;
    obs_t  o;
    logic [5:0] fn[4] = '{6'b100000, 6'b100010, 6'b100101, 6'b000000};
    logic [3:0] op[4] = '{4'b0011, 4'b0001, 4'b0010, 4'b0101};
    for (int i = 0; i < 4; i++) begin
      opcode_i = 6'b000000; funct_i = fn[i];
      push(1, 0, e_fetch(1));
      push(1, 0, e_decode(0));
      push(1, 0, mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, op[i], 0));
      push(1, 0, mk(4'd7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
      while (q.size() != 0) begin
        s = q.pop_front();
        mem_ready_i = s.rdy; zero_i = s.zr;
        @(negedge clk); o = observe(); checks++;
        if (o !== s.e) begin errors++; $display("FAIL rtype_%0d got %h required %h", i, o, s.e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_sw();
    step_t s;
    obs_t  o;
    opcode_i = 6'b100011; funct_i = 6'b111111;
    push(1, 0, e_fetch(1));
    push(1, 0, e_decode(0));
    push(1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0011, 0));
    push(0, 0, mk(4'd3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    push(0, 0, mk(4'd3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    push(1, 0, mk(4'd3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    push(1, 0, mk(4'd4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      mem_ready_i = s.rdy; zero_i = s.zr;
      @(negedge clk); o = observe(); checks++;
      if (o !== s.e) begin errors++; $display("FAIL lw_wait got %h required %h", o, s.e); end
      @(posedge clk); #1;
    end
    opcode_i = 6'b101011;
    push(0, 0, e_fetch(0));
    push(1, 0, e_fetch(1));
    push(1, 0, e_decode(0));
    push(1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0011, 0));
    push(0, 0, mk(4'd5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    push(1, 0, mk(4'd5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      mem_ready_i = s.rdy; zero_i = s.zr;
      @(negedge clk); o = observe(); checks++;
      if (o !== s.e) begin errors++; $display("FAIL sw_wait got %h required %h", o, s.e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t s;
    obs_t  o;
    logic [5:0] opc[3] = '{6'b000100, 6'b000101, 6'b000100};
    logic       zr[3]  = '{1'b0, 1'b0, 1'b1};
    logic       pcw[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      opcode_i = opc[i];
      push(1, 0, e_fetch(1));
      push(1, 0, e_decode(0));
      push(1, zr[i], mk(4'd8, pcw[i], 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'b0001, 0));
      while (q.size() != 0) begin
        s = q.pop_front();
        mem_ready_i = s.rdy; zero_i = s.zr;
        @(negedge clk); o = observe(); checks++;
        if (o !== s.e) begin errors++; $display("FAIL branch_%0d got %h required %h", i, o, s.e); end
        @(posedge clk); #1;
      end
    end
    zero_i = 1'b0;
  endtask

  task automatic test_itype();
    step_t s;
    obs_t  o;
    logic [5:0] opc[3] = '{6'b001000, 6'b001101, 6'b001111};
    logic       ext[3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] op[3]  = '{4'b0011, 4'b0010, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      opcode_i = opc[i];
      push(1, 0, e_fetch(1));
      push(1, 0, e_decode(0));
      push(1, 0, mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, ext[i], 1, 2'b10, 2'b00, op[i], 0));
      push(1, 0, mk(4'd11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
      while (q.size() != 0) begin
        s = q.pop_front();
        mem_ready_i = s.rdy; zero_i = s.zr;
        @(negedge clk); o = observe(); checks++;
        if (o !== s.e) begin errors++; $display("FAIL itype_%0d got %h required %h", i, o, s.e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    step_t s;
    obs_t  o;
    logic [5:0] opc[2] = '{6'b111111, 6'b000000};
    for (int i = 0; i < 2; i++) begin
      opcode_i = opc[i]; funct_i = 6'b111111;
      push(1, 0, e_fetch(1));
      push(1, 0, e_decode(1));
      push(0, 0, e_fetch(0));
      while (q.size() != 0) begin
        s = q.pop_front();
        mem_ready_i = s.rdy; zero_i = s.zr;
        @(negedge clk); o = observe(); checks++;
        if (o !== s.e) begin errors++; $display("FAIL illegal_%0d got %h required %h", i, o, s.e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    obs_t  o;
    opcode_i = 6'b101011;
    push(1, 0, e_fetch(1));
    push(1, 0, e_decode(0));
    push(1, 0, mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'b0011, 0));
    push(0, 0, mk(4'd5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
    while (q.size() != 0) begin
      s = q.pop_front();
      mem_ready_i = s.rdy; zero_i = s.zr;
      @(negedge clk); o = observe(); checks++;
      if (o !== s.e) begin errors++; $display("FAIL reset_mid_pre got %h required %h", o, s.e); end
      if (q.size() != 0) begin @(posedge clk); #1; end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_write_o !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_abort mw=%b state=%0d required 0/0", mem_write_o, state_o);
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== o || pc_write_o !== 1'b0 || ir_write_o !== 1'b0 || reg_write_o !== 1'b0 || mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold pcw=%b irw=%b rgw=%b mw=%b required 0/0/0/0",
               pc_write_o, ir_write_o, reg_write_o, mem_write_o);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    opcode_i = 6'b000010;
    push(1, 0, e_fetch(1));
    push(1, 0, e_decode(0));
    push(1, 0, mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'b0000, 0));
    push(1, 0, e_fetch(1));
    while (q.size() != 0) begin
      s = q.pop_front();
      mem_ready_i = s.rdy; zero_i = s.zr;
      @(negedge clk); o = observe(); checks++;
      if (o !== s.e) begin errors++; $display("FAIL reset_mid_resume got %h required %h", o, s.e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_branch();
    test_itype();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite-state controller that sequences the 32-bit ALU and its surrounding datapath through a multicycle MIPS execution. It sits beside the datapath and decodes the latched instruction's opcode and funct fields. From those it drives every mux select, write enable and the 4-bit ALU operation code. It supports wait-state memory through a ready handshake.

## Interface
- No parameters; all encodings are fixed constants in the package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU zero flag, for the current cycle's ALU result
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_read_o / mem_write_o  out  1  memory access strobes
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_o / pc_write_o / reg_write_o  out  1  register write enables
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- ext_sel_o  out  1  immediate extension: 0 = sign, 1 = zero
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b_o  out  2  ALU B input: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_operation_o  out  4  ALU code: ADD 0011, SUB 0001, OR 0010, LUI 0100, SLL 0101, NOP 0000
- illegal_o  out  1  one-cycle pulse marking an unsupported instruction
- state_o  out  4  current state, for debug

## Operation
- Supported instructions:
  - R-type (opcode 000000) with funct add 100000, sub 100010, or 100101, sll 000000.
  - addi 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- States and transitions:
  - FETCH 0: mem_read, iord=0, ALU computes PC+4 (src_a=0, src_b=01, ADD), pc_src=00.
    - ir_write and pc_write are asserted only when mem_ready_i=1.
    - Stays in FETCH while mem_ready_i=0; goes to DECODE on ready.
  - DECODE 1: ALU computes the branch target (src_a=0, src_b=11, ADD, ext=0).
    - Dispatches to MEM_ADDR (lw/sw), EXEC_R, EXEC_I (addi/ori/lui), BRANCH (beq/bne) or JUMP.
    - Any other opcode, or an R-type funct not listed, pulses illegal_o and returns to FETCH.
  - MEM_ADDR 2: src_a=1, src_b=10, ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ 3: mem_read, iord=1. Waits for mem_ready_i, then MEM_WB.
  - MEM_WB 4: reg_write, reg_dst=0, mem_to_reg=1, then FETCH.
  - MEM_WRITE 5: mem_write, iord=1. Waits for mem_ready_i, then FETCH.
  - EXEC_R 6: src_a=1, src_b=00. ALU code comes from funct (add→ADD, sub→SUB, or→OR, sll→SLL). Then R_WB.
  - R_WB 7: reg_write, reg_dst=1, mem_to_reg=0, then FETCH.
  - BRANCH 8: src_a=1, src_b=00, SUB, pc_src=01.
    - pc_write = zero_i for beq, ~zero_i for bne. Then FETCH.
  - JUMP 9: pc_src=10, pc_write=1, then FETCH.
  - EXEC_I 10: src_a=1, src_b=10. addi→ADD with ext=0; ori→OR with ext=1; lui→LUI. Then I_WB.
  - I_WB 11: reg_write, reg_dst=0, mem_to_reg=0, then FETCH.
  - Encodings 12–15 are unreachable; if entered, the FSM returns to FETCH with all outputs at NOP values.
- Default values for any output not named in a state: 0, alu_operation=0000.
- Opcode and funct are sampled only in DECODE and EXEC_R/EXEC_I; the IR stays stable after FETCH completes.

## Timing
- Outputs are combinational from the state register, plus gating by mem_ready_i and zero_i.
- The state register updates on the rising edge of clk.
- While reset=0, state=FETCH and all write enables (pc, ir, reg, mem_write) are forced to 0.
  - Other outputs take their FETCH values: mem_read=1, src_b=01, ADD.
  - illegal_o=0.
- Reset asserted mid-instruction aborts it immediately; no partial writes follow. Execution resumes at FETCH after release.
- Latency with zero wait states: j/beq/bne 3 cycles; R-type, I-type and sw 4 cycles; lw 5 cycles.
- Each cycle of mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Memory strobes are held steady until the ready cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode and funct constants
  - ALU operation codes, shared with the ALU
  - alu_src_b and pc_src select encodings
- Sub-module alu_op_decoder: combinational mapping of funct_i to alu_operation and a funct-valid flag. It is used in DECODE and EXEC_R.

## Test plan
- Reset held low with mem_ready_i=1:
  - state_o=0 and pc_write_o=ir_write_o=0.
  - After release, the first cycle shows pc_write_o=ir_write_o=1.
- add (opcode 0, funct 100000), zero wait states:
  - state sequence 0,1,6,7,0.
  - EXEC_R shows alu_operation=0011 and src_b=00; R_WB shows reg_write=1, reg_dst=1.
- lw with mem_ready_i low for 2 cycles in MEM_READ:
  - sequence 0,1,2,3,3,3,4,0.
  - mem_read=1 and iord=1 held throughout MEM_READ; MEM_WB shows mem_to_reg=1.
- beq with zero_i=0, then bne with zero_i=0:
  - beq gives pc_write=0; bne gives pc_write=1 with pc_src=01.
- ori, then lui:
  - ori shows ext_sel=1 with OR (0010); lui shows LUI (0100); both end with I_WB reg_write=1, reg_dst=0.
- Illegal cases:
  - opcode 111111 gives an illegal_o pulse in DECODE and a return to FETCH.
  - Reset asserted during MEM_WRITE gives mem_write_o=0 immediately and state 0.
